// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that shares one external 6-bit
// combinational adder among NREQ requesters. It uses a two-stage pipeline
// (operand register, then result register). Results return on a single
// valid/ready response channel, tagged with the index of the requester.
// Optional build macro ADDER_ARB_SAT_EN: when the adder reports a carry out,
// clamp the returned sum to 63.

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [6*NREQ-1:0]    req_x,
  input  logic [6*NREQ-1:0]    req_y,
  output logic [5:0]           add_x,
  output logic [5:0]           add_y,
  input  logic [5:0]           add_s,
  input  logic                 add_ov,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [5:0]           rsp_sum,
  output logic                 rsp_ov,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [CNTW-1:0]      done_cnt
);

  logic            op_vld_q, op_vld_d;
  logic [5:0]      op_x_q, op_x_d;
  logic [5:0]      op_y_q, op_y_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [5:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_ov_q, rsp_ov_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  logic            rsp_free, op_adv, op_free;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic [IDW:0]    ptr_inc;
  logic            accept;
  logic [5:0]      sel_x, sel_y;
  logic [5:0]      cap_sum;

  // Stage-advance conditions: the operand stage moves forward whenever the result stage can take it
  always_comb begin
    rsp_free = !rsp_valid_q || rsp_ready;
    op_adv   = op_vld_q && rsp_free;
    op_free  = !op_vld_q || op_adv;
  end

  // Round-robin search: the first valid requester at or after rr_ptr, wrapping past NREQ-1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Ready goes only to the granted requester; it is held low while reset is asserted so no handshake is seen
  always_comb begin
    req_ready = '0;
    if (rst_n && grant_found && op_free) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand mux for the granted slice, plus the capture value (clamped when saturation is built in)
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_x = req_x[6*i +: 6];
        sel_y = req_y[6*i +: 6];
      end
    end
`ifdef ADDER_ARB_SAT_EN
    cap_sum = add_ov ? 6'd63 : add_s;
`else
    cap_sum = add_s;
`endif
  end

  // Next-state logic for both pipeline stages, the round-robin pointer and the completion counter
  always_comb begin
    op_vld_d    = op_vld_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ov_d    = rsp_ov_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    done_cnt_d  = done_cnt_q;
    ptr_inc     = {1'b0, grant_idx} + {{IDW{1'b0}}, 1'b1};
    accept      = grant_found && op_free;

    if (accept) begin
      op_vld_d = 1'b1;
      op_x_d   = sel_x;
      op_y_d   = sel_y;
      op_id_d  = grant_idx;
      rr_ptr_d = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
    end else if (op_adv) begin
      op_vld_d = 1'b0;
    end

    if (op_adv) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = cap_sum;
      rsp_ov_d    = add_ov;
      rsp_id_d    = op_id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_valid_q && rsp_ready) begin
      done_cnt_d = done_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset drops any in-flight operand or result without producing a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q    <= 1'b0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_ov_q    <= 1'b0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      op_vld_q    <= op_vld_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ov_q    <= rsp_ov_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Output drive: the adder sees zeros while the operand stage is empty
  always_comb begin
    add_x     = op_vld_q ? op_x_q : 6'd0;
    add_y     = op_vld_q ? op_y_q : 6'd0;
    rsp_valid = rsp_valid_q;
    rsp_sum   = rsp_sum_q;
    rsp_ov    = rsp_ov_q;
    rsp_id    = rsp_id_q;
    busy      = op_vld_q || rsp_valid_q;
    done_cnt  = done_cnt_q;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter. It models the external adder and runs a
// transaction-level scoreboard on every falling edge. Scenario tasks follow,
// and each makes its own directed checks. It honours ADDER_ARB_SAT_EN.

module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

`ifdef ADDER_ARB_SAT_EN
  localparam logic [5:0] OV_SUM = 6'd63;
`else
  localparam logic [5:0] OV_SUM = 6'd0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [6*NREQ-1:0]    req_x;
  logic [6*NREQ-1:0]    req_y;
  logic [5:0]           add_x, add_y, add_s;
  logic                 add_ov;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [5:0]           rsp_sum;
  logic                 rsp_ov;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;
  logic [CNTW-1:0]      done_cnt;

  int checks   = 0;
  int failures = 0;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_ov(add_ov),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_ov(rsp_ov), .rsp_id(rsp_id),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // This block stands in for the external 6-bit adder.
  assign {add_ov, add_s} = {1'b0, add_x} + {1'b0, add_y};

  typedef struct {
    int id;
    int sum;
    int ov;
    int acceptEdge;
  } resp_t;

  resp_t expQ[$];
  int    mPtr = 0;
  int    mDone = 0;
  int    edgeCnt = 0;
  int    mG;
  logic [NREQ-1:0] mReady;
  bit    mValid;

  // This function computes the expected result with plain integer arithmetic.
  function automatic resp_t refResult(input int id, input int x, input int y, input int edgeNo);
    resp_t r;
    int total;
    total = x + y;
    r.id = id;
    r.ov = (total > 63) ? 1 : 0;
`ifdef ADDER_ARB_SAT_EN
    r.sum = (total > 63) ? 63 : total;
`else
    r.sum = total % 64;
`endif
    r.acceptEdge = edgeNo;
    return r;
  endfunction

  always @(posedge clk) edgeCnt++;

  // The scoreboard works as follows:
  // - Grant: the first valid requester from the pointer.
  // - Capacity: two results can be in flight.
  // - Delivery: results arrive in order, one edge after acceptance at the earliest.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      mPtr  = 0;
      mDone = 0;
    end else begin
      mG = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (mG < 0 && req_valid[(mPtr + k) % NREQ]) mG = (mPtr + k) % NREQ;
      end
      mReady = '0;
      if (mG >= 0 && (expQ.size() < 2 || rsp_ready)) mReady[mG] = 1'b1;
      checks++;
      if (req_ready !== mReady) begin
        failures++;
        $display("[TB] FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, mReady);
      end
      mValid = (expQ.size() > 0) && (edgeCnt - expQ[0].acceptEdge >= 1);
      checks++;
      if (rsp_valid !== mValid) begin
        failures++;
        $display("[TB] FAIL sb_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, mValid);
      end
      if (mValid) begin
        checks++;
        if (rsp_sum !== 6'(expQ[0].sum) || rsp_ov !== 1'(expQ[0].ov) || rsp_id !== IDW'(expQ[0].id)) begin
          failures++;
          $display("[TB] FAIL sb_rsp_data t=%0t got sum=%0d ov=%0d id=%0d exp sum=%0d ov=%0d id=%0d",
                   $time, rsp_sum, rsp_ov, rsp_id, expQ[0].sum, expQ[0].ov, expQ[0].id);
        end
      end
      checks++;
      if (busy !== (expQ.size() > 0)) begin
        failures++;
        $display("[TB] FAIL sb_busy t=%0t got=%b exp=%0d", $time, busy, expQ.size() > 0);
      end
      checks++;
      if (done_cnt !== CNTW'(mDone)) begin
        failures++;
        $display("[TB] FAIL sb_done_cnt t=%0t got=%0d exp=%0d", $time, done_cnt, CNTW'(mDone));
      end
      if (mValid && rsp_ready) begin
        void'(expQ.pop_front());
        mDone++;
      end
      if (mG >= 0 && mReady != '0) begin
        expQ.push_back(refResult(mG, int'(req_x[6*mG +: 6]), int'(req_y[6*mG +: 6]), edgeCnt + 1));
        mPtr = (mG + 1) % NREQ;
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic sendOne(input int id, input int x, input int y,
                         output logic [5:0] s, output logic o, output logic [IDW-1:0] rid, output bit ok);
    ok = 0; s = '0; o = 1'b0; rid = '0;
    @(posedge clk); #1;
    req_x[6*id +: 6] = 6'(x);
    req_y[6*id +: 6] = 6'(y);
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (ok) begin
      ok = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (rsp_valid) begin s = rsp_sum; o = rsp_ov; rid = rsp_id; ok = 1; break; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #12;
    checks++;
    if (req_ready !== 4'h0) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_valid_busy got=%b/%b exp=0/0", rsp_valid, busy);
    end
    checks++;
    if (rsp_sum !== 6'd0 || rsp_ov !== 1'b0 || rsp_id !== 2'd0 || done_cnt !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_rsp_regs got sum=%0d ov=%0d id=%0d cnt=%0d exp all 0", rsp_sum, rsp_ov, rsp_id, done_cnt);
    end
    checks++;
    if (add_x !== 6'd0 || add_y !== 6'd0) begin
      failures++; $display("[TB] FAIL reset_adder_drive got x=%0d y=%0d exp 0/0", add_x, add_y);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    doReset();
    @(posedge clk); #1;
    req_x[12 +: 6] = 6'd5;
    req_y[12 +: 6] = 6'd9;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL single_grant got=%b exp=0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 6'd14 || rsp_ov !== 1'b0 || rsp_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL single_rsp got v=%b sum=%0d ov=%0d id=%0d exp v=1 sum=14 ov=0 id=2", rsp_valid, rsp_sum, rsp_ov, rsp_id);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 4'd1 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL single_done got cnt=%0d busy=%b exp cnt=1 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_round_robin();
    doReset();
    @(posedge clk); #1;
    req_x = {$urandom, $urandom};
    req_y = {$urandom, $urandom};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++; $display("[TB] FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4)) begin
          failures++; $display("[TB] FAIL rr_rsp_id k=%0d got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, (k - 2) % 4);
        end
      end
      @(posedge clk); #1;
      req_x[6*(k%4) +: 6] = 6'($urandom);
      req_y[6*(k%4) +: 6] = 6'($urandom);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rr_drain got busy=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    int xs[4] = '{63, 32, 40, 0};
    int ys[4] = '{1, 32, 23, 0};
    logic [5:0] es[4];
    logic       eo[4];
    logic [5:0] s;
    logic       o;
    logic [IDW-1:0] rid;
    bit ok;
    es = '{OV_SUM, OV_SUM, 6'd63, 6'd0};
    eo = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      sendOne(c, xs[c], ys[c], s, o, rid, ok);
      checks++;
      if (!ok || s !== es[c] || o !== eo[c] || rid !== IDW'(c)) begin
        failures++;
        $display("[TB] FAIL overflow_case%0d got ok=%0d sum=%0d ov=%0d id=%0d exp sum=%0d ov=%0d id=%0d",
                 c, ok, s, o, rid, es[c], eo[c], c);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [NREQ-1:0] accMask;
    logic [5:0] heldSum;
    logic [IDW-1:0] heldId;
    acc = 0; heldSum = '0; heldId = '0;
    doReset();
    @(posedge clk); #1;
    req_x = {$urandom, $urandom};
    req_y = {$urandom, $urandom};
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL bp_stall_ready k=%0d got=%b exp=0000", k, req_ready); end
        if (k == 2) begin
          heldSum = rsp_sum; heldId = rsp_id;
        end else begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_sum !== heldSum || rsp_id !== heldId) begin
            failures++; $display("[TB] FAIL bp_rsp_stable k=%0d got v=%b sum=%0d id=%0d exp v=1 sum=%0d id=%0d", k, rsp_valid, rsp_sum, rsp_id, heldSum, heldId);
          end
        end
      end
      accMask = req_ready & req_valid;
      acc += $countones(accMask);
      @(posedge clk); #1;
      req_valid = req_valid & ~accMask;
      if (acc == 2) req_valid[0] = 1'b1;
    end
    checks++;
    if (acc != 2) begin failures++; $display("[TB] FAIL bp_accepts got=%0d exp=2", acc); end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin failures++; $display("[TB] FAIL bp_first_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin failures++; $display("[TB] FAIL bp_second_rsp got v=%b id=%0d exp v=1 id=3", rsp_valid, rsp_id); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle got busy=%b v=%b exp 0/0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    doReset();
    @(posedge clk); #1;
    req_x = {$urandom, $urandom};
    req_y = {$urandom, $urandom};
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || add_x !== req_x[11:6]) begin
      failures++; $display("[TB] FAIL rmid_setup got busy=%b v=%b add_x=%0d exp 1/1/%0d", busy, rsp_valid, add_x, req_x[11:6]);
    end
    #2;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      failures++; $display("[TB] FAIL rmid_async_ctrl got v=%b busy=%b ready=%b exp 0/0/0000", rsp_valid, busy, req_ready);
    end
    checks++;
    if (add_x !== 6'd0 || add_y !== 6'd0 || rsp_sum !== 6'd0 || rsp_id !== 2'd0 || done_cnt !== 4'd0) begin
      failures++; $display("[TB] FAIL rmid_async_data got ax=%0d ay=%0d sum=%0d id=%0d cnt=%0d exp all 0", add_x, add_y, rsp_sum, rsp_id, done_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      failures++; $display("[TB] FAIL rmid_after got v=%b ready=%b exp v=0 ready=0010", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] accMask;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      accMask = req_ready & req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (accMask[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_x[6*i +: 6] = 6'($urandom);
          req_y[6*i +: 6] = 6'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL random_drain got busy=%b exp=0", busy); end
  endtask

  task automatic test_counter_wrap();
    logic [5:0] s;
    logic       o;
    logic [IDW-1:0] rid;
    bit ok;
    doReset();
    for (int n = 0; n < 17; n++) begin
      sendOne(n % NREQ, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), s, o, rid, ok);
      if (!ok) begin
        checks++; failures++;
        $display("[TB] FAIL wrap_timeout n=%0d got no response exp response", n);
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 4'd1) begin failures++; $display("[TB] FAIL wrap_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
